// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the execute stage and a
// word-addressed data memory with a request/acknowledge handshake.
// Stores are lane-replicated with byte strobes; loads are extracted
// little-endian and sign/zero-extended before being returned to writeback.
// Optional feature: define MISALIGN_EXC_EN to enable alignment checking.
// With it, misaligned half/word accesses raise exc_adel/exc_ades and
// capture badvaddr instead of touching memory. Without it, those outputs
// stay 0 and the low address bits are simply ignored for wide accesses.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_memwrite,
    input  logic              req_op_lb,
    input  logic              req_op_lbu,
    input  logic              req_op_lh,
    input  logic              req_op_lhu,
    input  logic              req_op_lw,
    input  logic [4:0]        req_rd,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              rsp_valid,
    output logic              rsp_load,
    output logic [31:0]       rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              stall,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic [ADDR_W-1:0] badvaddr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state_r;
    logic [1:0]  addr_lo_r;
    logic [1:0]  size_r;
    logic        sext_r;
    logic        load_r;
    logic [4:0]  rd_r;

    logic        is_store_s;
    logic        is_load_s;
    logic [1:0]  size_s;
    logic        sext_s;
    logic [3:0]  we_s;
    logic [31:0] wdata_s;
    logic        misalign_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] load_data_s;

    // Classify the incoming request: store wins over loads, then lw > lh > lhu > lb > lbu.
    always_comb begin
        is_store_s = |req_memwrite;
        is_load_s  = !is_store_s &&
                     (req_op_lw || req_op_lh || req_op_lhu || req_op_lb || req_op_lbu);
        size_s     = SZ_BYTE;
        sext_s     = 1'b0;
        if (is_store_s) begin
            case (req_memwrite)
                4'b1111: size_s = SZ_WORD;
                4'b0011: size_s = SZ_HALF;
                default: size_s = SZ_BYTE;
            endcase
        end else if (req_op_lw) begin
            size_s = SZ_WORD;
        end else if (req_op_lh) begin
            size_s = SZ_HALF;
            sext_s = 1'b1;
        end else if (req_op_lhu) begin
            size_s = SZ_HALF;
        end else if (req_op_lb) begin
            size_s = SZ_BYTE;
            sext_s = 1'b1;
        end else begin
            size_s = SZ_BYTE;
        end
    end

    // Byte strobes and lane-replicated write data for stores; loads write nothing.
    always_comb begin
        we_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        if (is_store_s) begin
            case (size_s)
                SZ_WORD: begin
                    we_s    = 4'b1111;
                    wdata_s = req_wdata;
                end
                SZ_HALF: begin
                    we_s    = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_s = {2{req_wdata[15:0]}};
                end
                default: begin
                    we_s    = 4'b0001 << req_addr[1:0];
                    wdata_s = {4{req_wdata[7:0]}};
                end
            endcase
        end else begin
            we_s    = 4'b0000;
            wdata_s = 32'h0000_0000;
        end
    end

    // Alignment check: halves need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
`ifdef MISALIGN_EXC_EN
        case (size_s)
            SZ_HALF: misalign_s = req_addr[0];
            SZ_WORD: misalign_s = |req_addr[1:0];
            default: misalign_s = 1'b0;
        endcase
`else
        misalign_s = 1'b0;
`endif
    end

    // Little-endian lane extraction and extension of the returned word.
    always_comb begin
        case (addr_lo_r)
            2'd0:    byte_s = mem_rdata[7:0];
            2'd1:    byte_s = mem_rdata[15:8];
            2'd2:    byte_s = mem_rdata[23:16];
            default: byte_s = mem_rdata[31:24];
        endcase
        if (addr_lo_r[1]) begin
            half_s = mem_rdata[31:16];
        end else begin
            half_s = mem_rdata[15:0];
        end
        case (size_r)
            SZ_WORD: load_data_s = mem_rdata;
            SZ_HALF: load_data_s = sext_r ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
            default: load_data_s = sext_r ? {{24{byte_s[7]}}, byte_s} : {24'h00_0000, byte_s};
        endcase
    end

    // Access FSM with all outputs registered; reset dominates a same-cycle mem_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            addr_lo_r <= 2'd0;
            size_r    <= SZ_BYTE;
            sext_r    <= 1'b0;
            load_r    <= 1'b0;
            rd_r      <= 5'd0;
            req_ready <= 1'b1;
            stall     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
            rsp_valid <= 1'b0;
            rsp_load  <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_rd    <= 5'd0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
            badvaddr  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready && (is_store_s || is_load_s)) begin
                        if (misalign_s) begin
                            exc_adel <= is_load_s;
                            exc_ades <= is_store_s;
                            badvaddr <= req_addr;
                        end else begin
                            addr_lo_r <= req_addr[1:0];
                            size_r    <= size_s;
                            sext_r    <= sext_s;
                            load_r    <= is_load_s;
                            rd_r      <= req_rd;
                            mem_en    <= 1'b1;
                            mem_we    <= we_s;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= wdata_s;
                            req_ready <= 1'b0;
                            stall     <= 1'b1;
                            state_r   <= ST_ACCESS;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 4'b0000;
                        rsp_valid <= 1'b1;
                        rsp_load  <= load_r;
                        rsp_rdata <= load_r ? load_data_s : 32'h0000_0000;
                        rsp_rd    <= rd_r;
                        state_r   <= ST_RESP;
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 4'b0000;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
